// File: rtl/z80fi_insn_recorder_pkg.sv
// Shared cycle-type codes, record slot widths and recorder state type.
package z80fi_insn_recorder_pkg;

  localparam int Z80FI_MCYCLE_W = 3;
  localparam int Z80FI_TCOUNT_W = 4;

  localparam logic [Z80FI_MCYCLE_W-1:0] CYCLE_NONE     = 3'd0;
  localparam logic [Z80FI_MCYCLE_W-1:0] CYCLE_M1       = 3'd1;
  localparam logic [Z80FI_MCYCLE_W-1:0] CYCLE_RDWR     = 3'd2;
  localparam logic [Z80FI_MCYCLE_W-1:0] CYCLE_IO       = 3'd3;
  localparam logic [Z80FI_MCYCLE_W-1:0] CYCLE_INTACK   = 3'd4;
  localparam logic [Z80FI_MCYCLE_W-1:0] CYCLE_INTERNAL = 3'd5;

  localparam logic [Z80FI_TCOUNT_W-1:0] TCOUNT_MAX = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rec_state_t;

endpackage

// File: rtl/z80fi_mcycle_slots.sv
// M-cycle slot accumulator: per-slot type and saturating T-count, write index and drop flag.
module z80fi_mcycle_slots
  import z80fi_insn_recorder_pkg::*;
#(
  parameter int MAX_MCYCLES = 6
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  clear_tick,
  input  logic                                  advance,
  input  logic [Z80FI_MCYCLE_W-1:0]             advance_type,
  input  logic                                  tick,
  output logic [Z80FI_MCYCLE_W*MAX_MCYCLES-1:0] types,
  output logic [Z80FI_TCOUNT_W*MAX_MCYCLES-1:0] counts,
  output logic                                  ovf
);

  localparam int IDXW = (MAX_MCYCLES > 1) ? $clog2(MAX_MCYCLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MAX_MCYCLES - 1);

  logic [Z80FI_MCYCLE_W-1:0] type_reg  [MAX_MCYCLES];
  logic [Z80FI_TCOUNT_W-1:0] count_reg [MAX_MCYCLES];
  logic [IDXW-1:0]           idx_reg;
  logic                      ovf_reg;

  logic [Z80FI_MCYCLE_W-1:0] type_next  [MAX_MCYCLES];
  logic [Z80FI_TCOUNT_W-1:0] count_next [MAX_MCYCLES];
  logic [IDXW-1:0]           idx_next;
  logic                      ovf_next;

  // Continuing-record view: this clk's start is applied before its tstate.
  always_comb begin
    type_next  = type_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    ovf_next   = ovf_reg;
    if (advance) begin
      if (idx_reg != LAST_IDX) begin
        idx_next = idx_reg + IDXW'(1);
        for (int i = 0; i < MAX_MCYCLES; i++) begin
          if (idx_next == IDXW'(i)) begin
            type_next[i]  = advance_type;
            count_next[i] = '0;
          end
        end
      end else begin
        ovf_next = 1'b1;
      end
    end
    // Once a start has been dropped, no slot owns the following T-states.
    if (tick && !ovf_next) begin
      for (int i = 0; i < MAX_MCYCLES; i++) begin
        if (idx_next == IDXW'(i) && count_next[i] != TCOUNT_MAX) begin
          count_next[i] = count_next[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_MCYCLES; i++) begin
        type_reg[i]  <= CYCLE_NONE;
        count_reg[i] <= '0;
      end
      idx_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < MAX_MCYCLES; i++) begin
        type_reg[i]  <= (i == 0) ? CYCLE_M1 : CYCLE_NONE;
        count_reg[i] <= (i == 0 && clear_tick) ? 4'd1 : 4'd0;
      end
      idx_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      type_reg  <= type_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      ovf_reg   <= ovf_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_MCYCLES; gi++) begin : g_flat
      assign types[Z80FI_MCYCLE_W*gi +: Z80FI_MCYCLE_W]  = type_next[gi];
      assign counts[Z80FI_TCOUNT_W*gi +: Z80FI_TCOUNT_W] = count_next[gi];
    end
  endgenerate

  assign ovf = ovf_next;

endmodule

// File: rtl/z80fi_insn_recorder.sv
// Builds one retirement record per instruction from the core's M-cycle, T-state and byte strobes.
module z80fi_insn_recorder
  import z80fi_insn_recorder_pkg::*;
#(
  parameter int MAX_MCYCLES    = 6,
  parameter int MAX_INSN_BYTES = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cpu_mcycle_start,
  input  logic [Z80FI_MCYCLE_W-1:0]             cpu_mcycle_type,
  input  logic                                  cpu_tstate,
  input  logic                                  cpu_insn_byte_valid,
  input  logic [7:0]                            cpu_insn_byte,
  input  logic                                  cpu_insn_done,
  output logic                                  z80fi_valid,
  output logic [8*MAX_INSN_BYTES-1:0]           z80fi_insn,
  output logic [2:0]                            z80fi_insn_len,
  output logic [Z80FI_MCYCLE_W*MAX_MCYCLES-1:0] z80fi_mcycle_types,
  output logic [Z80FI_TCOUNT_W*MAX_MCYCLES-1:0] z80fi_tcycles,
  output logic                                  z80fi_overflow
);

  localparam logic [2:0] LEN_MAX = 3'(MAX_INSN_BYTES);

  rec_state_t state_reg, state_next;

  logic run, m1_start, retire, fresh;
  assign run      = (state_reg == ST_RUN);
  assign m1_start = cpu_mcycle_start && (cpu_mcycle_type == CYCLE_M1);
  assign retire   = run && cpu_insn_done;
  assign fresh    = m1_start && (!run || cpu_insn_done);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (m1_start) state_next = ST_RUN;
      ST_RUN:  if (cpu_insn_done) state_next = m1_start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // On a back-to-back boundary the done clk's tstate/byte belong to the retiring record.
  logic [Z80FI_MCYCLE_W*MAX_MCYCLES-1:0] slot_types;
  logic [Z80FI_TCOUNT_W*MAX_MCYCLES-1:0] slot_counts;
  logic                                  slot_ovf;

  z80fi_mcycle_slots #(.MAX_MCYCLES(MAX_MCYCLES)) u_slots (
    .clk          (clk),
    .reset        (reset),
    .clear        (fresh),
    .clear_tick   (cpu_tstate && !run),
    .advance      (run && cpu_mcycle_start && !cpu_insn_done),
    .advance_type (cpu_mcycle_type),
    .tick         (run && cpu_tstate),
    .types        (slot_types),
    .counts       (slot_counts),
    .ovf          (slot_ovf)
  );

  logic [7:0] byte_reg  [MAX_INSN_BYTES];
  logic [7:0] byte_next [MAX_INSN_BYTES];
  logic [2:0] len_reg, len_next;
  logic       bovf_reg, bovf_next;

  always_comb begin
    byte_next = byte_reg;
    len_next  = len_reg;
    bovf_next = bovf_reg;
    if (run && cpu_insn_byte_valid) begin
      if (len_reg != LEN_MAX) begin
        for (int i = 0; i < MAX_INSN_BYTES; i++) begin
          if (len_reg == 3'(i)) byte_next[i] = cpu_insn_byte;
        end
        len_next = len_reg + 3'd1;
      end else begin
        bovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_INSN_BYTES; i++) byte_reg[i] <= '0;
      len_reg  <= '0;
      bovf_reg <= 1'b0;
    end else if (fresh) begin
      for (int i = 0; i < MAX_INSN_BYTES; i++) begin
        byte_reg[i] <= (i == 0 && !run && cpu_insn_byte_valid) ? cpu_insn_byte : 8'h00;
      end
      len_reg  <= (!run && cpu_insn_byte_valid) ? 3'd1 : 3'd0;
      bovf_reg <= 1'b0;
    end else begin
      byte_reg <= byte_next;
      len_reg  <= len_next;
      bovf_reg <= bovf_next;
    end
  end

  logic [8*MAX_INSN_BYTES-1:0] insn_next;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_INSN_BYTES; gi++) begin : g_insn
      assign insn_next[8*gi +: 8] = byte_next[gi];
    end
  endgenerate

  logic                                  valid_reg;
  logic [8*MAX_INSN_BYTES-1:0]           insn_reg;
  logic [2:0]                            out_len_reg;
  logic [Z80FI_MCYCLE_W*MAX_MCYCLES-1:0] types_reg;
  logic [Z80FI_TCOUNT_W*MAX_MCYCLES-1:0] tcycles_reg;
  logic                                  ovf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      insn_reg    <= '0;
      out_len_reg <= '0;
      types_reg   <= '0;
      tcycles_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      valid_reg <= retire;
      if (retire) begin
        insn_reg    <= insn_next;
        out_len_reg <= len_next;
        types_reg   <= slot_types;
        tcycles_reg <= slot_counts;
        ovf_reg     <= slot_ovf || bovf_next;
      end
    end
  end

  assign z80fi_valid        = valid_reg;
  assign z80fi_insn         = insn_reg;
  assign z80fi_insn_len     = out_len_reg;
  assign z80fi_mcycle_types = types_reg;
  assign z80fi_tcycles      = tcycles_reg;
  assign z80fi_overflow     = ovf_reg;

endmodule
